// File: rtl/param_sync_fifo.sv
`default_nettype none
// ==========================================================================
// param_sync_fifo -- single-clock FIFO, registered-read or first-word-fall-through
// Revision: 1.0
// ==========================================================================
module param_sync_fifo #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                wr_en,
  input  logic [FIFO_WIDTH-1:0]               data_in,
  input  logic                                rd_en,
  output logic [FIFO_WIDTH-1:0]               data_out,
  output logic                                rd_valid,
  output logic                                wr_ack,
  output logic                                overflow,
  output logic                                underflow,
  output logic                                full,
  output logic                                empty,
  output logic                                almostfull,
  output logic                                almostempty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count
);

  localparam int C_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int C_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [C_PTR_W-1:0] C_PTR_LAST = C_PTR_W'(FIFO_DEPTH - 1);
  localparam logic [C_CNT_W-1:0] C_DEPTH    = C_CNT_W'(FIFO_DEPTH);
  localparam logic [C_CNT_W-1:0] C_AF       = C_CNT_W'(AF_THRESH);
  localparam logic [C_CNT_W-1:0] C_AE       = C_CNT_W'(AE_THRESH);

  generate
    if (FIFO_DEPTH < 2 || AE_THRESH < 1 || AE_THRESH >= AF_THRESH ||
        AF_THRESH > FIFO_DEPTH - 1) begin : g_bad_cfg
      $error("param_sync_fifo: illegal FIFO_DEPTH / AE_THRESH / AF_THRESH combination");
    end
  endgenerate

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [C_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [C_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [C_CNT_W-1:0]    count_q, count_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  w_wr_accept;
  logic                  w_rd_accept;

  assign full        = (count_q == C_DEPTH);
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= C_AF);
  assign almostempty = (count_q <= C_AE);
  assign count       = count_q;
  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  // Reset and flush both veto any operation in their cycle, memory write included
  assign w_wr_accept = wr_en & ~full  & ~flush & ~rst;
  assign w_rd_accept = rd_en & ~empty & ~flush & ~rst;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wr_ack_d    = w_wr_accept;
    overflow_d  = wr_en & full  & ~flush;
    underflow_d = rd_en & empty & ~flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_wr_accept) begin
        wr_ptr_d = (wr_ptr_q == C_PTR_LAST) ? '0 : wr_ptr_q + C_PTR_W'(1);
      end
      if (w_rd_accept) begin
        rd_ptr_d = (rd_ptr_q == C_PTR_LAST) ? '0 : rd_ptr_q + C_PTR_W'(1);
      end
      if (w_wr_accept && !w_rd_accept) begin
        count_d = count_q + C_CNT_W'(1);
      end else if (!w_wr_accept && w_rd_accept) begin
        count_d = count_q - C_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = mem_q[rd_ptr_q];
      assign rd_valid = ~empty;
    end else begin : g_regread
      logic [FIFO_WIDTH-1:0] dout_q;
      logic                  rd_valid_q;

      // Flush deliberately leaves dout_q alone; only reset clears it
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q     <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= w_rd_accept;
          if (w_rd_accept) begin
            dout_q <= mem_q[rd_ptr_q];
          end
        end
      end

      assign data_out = dout_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
`default_nettype none
// tb_param_sync_fifo -- drives three FIFO configurations with shared stimulus and
// compares each against a queue-based reference model plus directed expectations.
module tb_param_sync_fifo;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst, flush, wr_en, rd_en;
  logic [15:0] data_in;
  logic [15:0] dout [N];
  logic        rdv [N];
  logic        ack [N];
  logic        ovf [N];
  logic        udf [N];
  logic        ful [N];
  logic        emp [N];
  logic        af  [N];
  logic        ae  [N];
  logic [3:0]  cnt_a, cnt_b;
  logic [2:0]  cnt_6;

  int n_vec;
  int n_err;

  // reference model: one queue per instance plus last-cycle handshake flags
  logic [15:0] mq0 [$];
  logic [15:0] mq1 [$];
  logic [15:0] mq2 [$];
  logic        e_ack [N];
  logic        e_ovf [N];
  logic        e_udf [N];
  logic        e_rdv [N];
  logic [15:0] e_dout [N];

  always #5 clk = ~clk;

  param_sync_fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) u_d8 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout[0]), .rd_valid(rdv[0]), .wr_ack(ack[0]), .overflow(ovf[0]), .underflow(udf[0]),
    .full(ful[0]), .empty(emp[0]), .almostfull(af[0]), .almostempty(ae[0]), .count(cnt_a));

  param_sync_fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(6), .AF_THRESH(4), .AE_THRESH(2), .FWFT(0)) u_d6 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout[1]), .rd_valid(rdv[1]), .wr_ack(ack[1]), .overflow(ovf[1]), .underflow(udf[1]),
    .full(ful[1]), .empty(emp[1]), .almostfull(af[1]), .almostempty(ae[1]), .count(cnt_6));

  param_sync_fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout[2]), .rd_valid(rdv[2]), .wr_ack(ack[2]), .overflow(ovf[2]), .underflow(udf[2]),
    .full(ful[2]), .empty(emp[2]), .almostfull(af[2]), .almostempty(ae[2]), .count(cnt_b));

  function automatic int dep(int k);
    return (k == 1) ? 6 : 8;
  endfunction
  function automatic int afth(int k);
    return (k == 1) ? 4 : 6;
  endfunction
  function automatic bit is_fwft(int k);
    return (k == 2);
  endfunction
  function automatic logic [3:0] cnt(int k);
    case (k)
      0:       return cnt_a;
      1:       return {1'b0, cnt_6};
      default: return cnt_b;
    endcase
  endfunction

  function automatic int msize(int k);
    case (k)
      0:       return mq0.size();
      1:       return mq1.size();
      default: return mq2.size();
    endcase
  endfunction
  function automatic logic [15:0] mfront(int k);
    logic [15:0] v = 16'h0000;
    case (k)
      0:       if (mq0.size() > 0) v = mq0[0];
      1:       if (mq1.size() > 0) v = mq1[0];
      default: if (mq2.size() > 0) v = mq2[0];
    endcase
    return v;
  endfunction
  task automatic mpush(int k, logic [15:0] v);
    case (k)
      0:       mq0.push_back(v);
      1:       mq1.push_back(v);
      default: mq2.push_back(v);
    endcase
  endtask
  task automatic mpop(int k);
    case (k)
      0:       void'(mq0.pop_front());
      1:       void'(mq1.pop_front());
      default: void'(mq2.pop_front());
    endcase
  endtask
  task automatic mclear(int k);
    case (k)
      0:       mq0.delete();
      1:       mq1.delete();
      default: mq2.delete();
    endcase
  endtask

  task automatic model_step(int k);
    int sz;
    bit is_full, is_empty, wa, ra;
    sz       = msize(k);
    is_full  = (sz == dep(k));
    is_empty = (sz == 0);
    if (rst) begin
      mclear(k);
      e_ack[k] = 1'b0; e_ovf[k] = 1'b0; e_udf[k] = 1'b0; e_rdv[k] = 1'b0; e_dout[k] = 16'h0;
    end else if (flush) begin
      mclear(k);
      e_ack[k] = 1'b0; e_ovf[k] = 1'b0; e_udf[k] = 1'b0; e_rdv[k] = 1'b0;
    end else begin
      wa = wr_en && !is_full;
      ra = rd_en && !is_empty;
      if (ra) begin
        e_dout[k] = mfront(k);
        mpop(k);
      end
      if (wa) mpush(k, data_in);
      e_ack[k] = wa;
      e_ovf[k] = wr_en && is_full;
      e_udf[k] = rd_en && is_empty;
      e_rdv[k] = ra;
    end
  endtask

  task automatic tick();
    for (int k = 0; k < N; k++) model_step(k);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; wr_en = 1'b1; rd_en = 1'b1; data_in = 16'(($urandom));
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; data_in = 16'hDEAD;
    tick();
    tick();
    idle();
    for (int k = 0; k < N; k++) begin
      n_vec++;
      if ({emp[k], ae[k], ful[k], af[k], ack[k], ovf[k], udf[k], rdv[k]} !== 8'b1100_0000) begin
        n_err++;
        $display("FAIL reset_flags[%0d]: got %b want 11000000", k,
                 {emp[k], ae[k], ful[k], af[k], ack[k], ovf[k], udf[k], rdv[k]});
      end
      n_vec++;
      if (cnt(k) !== 4'd0) begin
        n_err++;
        $display("FAIL reset_count[%0d]: got %0d want 0", k, cnt(k));
      end
      if (!is_fwft(k)) begin
        n_vec++;
        if (dout[k] !== 16'h0000) begin
          n_err++;
          $display("FAIL reset_dout[%0d]: got %h want 0000", k, dout[k]);
        end
      end
    end
  endtask

  task automatic test_fill();
    logic [7:0] got, want;
    idle();
    for (int i = 1; i <= 9; i++) begin
      wr_en = 1'b1; data_in = 16'(i);
      tick();
      got = {ack[0], ovf[0], ful[0], af[0], ae[0], cnt(0)[2:0]};
      if (i <= 8) want = {1'b1, 1'b0, i == 8, i >= 6, i <= 2, 3'(i)};
      else        want = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
      n_vec++;
      if (got !== want || cnt(0) !== ((i <= 8) ? 4'(i) : 4'd8)) begin
        n_err++;
        $display("FAIL fill[%0d]: got ack/ovf/full/af/ae/cnt=%b cnt=%0d want %b", i, got, cnt(0), want);
      end
    end
    idle();
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) begin
        n_vec++;
        if (dout[2] !== 16'(i) || rdv[2] !== 1'b1) begin
          n_err++;
          $display("FAIL fwft_head[%0d]: got %h/%b want %h/1", i, dout[2], rdv[2], 16'(i));
        end
      end
      rd_en = 1'b1;
      tick();
      n_vec++;
      if (i <= 8) begin
        if ({rdv[0], udf[0], emp[0]} !== {1'b1, 1'b0, i == 8} || dout[0] !== 16'(i) ||
            cnt(0) !== 4'(8 - i)) begin
          n_err++;
          $display("FAIL drain[%0d]: got dout=%h rdv=%b udf=%b empty=%b cnt=%0d want dout=%h",
                   i, dout[0], rdv[0], udf[0], emp[0], cnt(0), 16'(i));
        end
      end else begin
        if ({rdv[0], udf[0], emp[0]} !== 3'b011 || cnt(0) !== 4'd0) begin
          n_err++;
          $display("FAIL drain_underflow: got rdv/udf/empty=%b cnt=%0d want 011 cnt=0",
                   {rdv[0], udf[0], emp[0]}, cnt(0));
        end
      end
    end
    idle();
    tick();
    n_vec++;
    if ({rdv[0], udf[0]} !== 2'b00) begin
      n_err++;
      $display("FAIL drain_idle: got rdv/udf=%b want 00", {rdv[0], udf[0]});
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = -2; i < 0; i++) begin
      wr_en = 1'b1; data_in = 16'(32'h1000 + i);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; rd_en = 1'b0; data_in = 16'(32'h1000 + i);
      tick();
      n_vec++;
      if ({ful[1], af[1], ae[1], emp[1], ack[1]} !== 5'b00001 || cnt(1) !== 4'd3) begin
        n_err++;
        $display("FAIL wrap_wr[%0d]: got full/af/ae/empty/ack=%b cnt=%0d want 00001 cnt=3",
                 i, {ful[1], af[1], ae[1], emp[1], ack[1]}, cnt(1));
      end
      wr_en = 1'b0; rd_en = 1'b1;
      tick();
      n_vec++;
      if (dout[1] !== 16'(32'h1000 + i - 2) || rdv[1] !== 1'b1 || ae[1] !== 1'b1 || cnt(1) !== 4'd2) begin
        n_err++;
        $display("FAIL wrap_rd[%0d]: got dout=%h rdv=%b ae=%b cnt=%0d want dout=%h",
                 i, dout[1], rdv[1], ae[1], cnt(1), 16'(32'h1000 + i - 2));
      end
    end
    idle();
  endtask

  task automatic test_simul();
    logic [15:0] want;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; data_in = 16'(32'h2000 + i);
      tick();
    end
    for (int j = 0; j < 5; j++) begin
      wr_en = 1'b1; rd_en = 1'b1; data_in = 16'(32'h2100 + j);
      tick();
      want = (j < 4) ? 16'(32'h2000 + j) : 16'h2100;
      n_vec++;
      if (cnt(0) !== 4'd4 || ack[0] !== 1'b1 || rdv[0] !== 1'b1 || dout[0] !== want) begin
        n_err++;
        $display("FAIL simul[%0d]: got cnt=%0d ack=%b rdv=%b dout=%h want cnt=4 ack=1 rdv=1 dout=%h",
                 j, cnt(0), ack[0], rdv[0], dout[0], want);
      end
    end
    rd_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; data_in = 16'(32'h2200 + i);
      tick();
    end
    n_vec++;
    if (ful[0] !== 1'b1) begin
      n_err++;
      $display("FAIL simul_full: got %b want 1", ful[0]);
    end
    wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h2FFF;
    tick();
    n_vec++;
    if ({ovf[0], ack[0], rdv[0], ful[0]} !== 4'b1010 || cnt(0) !== 4'd7 || dout[0] !== 16'h2101) begin
      n_err++;
      $display("FAIL simul_at_full: got ovf/ack/rdv/full=%b cnt=%0d dout=%h want 1010 cnt=7 dout=2101",
               {ovf[0], ack[0], rdv[0], ful[0]}, cnt(0), dout[0]);
    end
    idle();
  endtask

  task automatic test_flush_rst();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; data_in = 16'(32'h3000 + i);
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    flush = 1'b1; wr_en = 1'b1; rd_en = 1'b0; data_in = 16'h3AAA;
    tick();
    n_vec++;
    if ({emp[0], ack[0], rdv[0], ovf[0]} !== 4'b1000 || cnt(0) !== 4'd0 || dout[0] !== 16'h3000) begin
      n_err++;
      $display("FAIL flush: got empty/ack/rdv/ovf=%b cnt=%0d dout=%h want 1000 cnt=0 dout=3000",
               {emp[0], ack[0], rdv[0], ovf[0]}, cnt(0), dout[0]);
    end
    idle();
    rd_en = 1'b1;
    tick();
    n_vec++;
    if ({udf[0], rdv[0]} !== 2'b10) begin
      n_err++;
      $display("FAIL flush_then_read: got udf/rdv=%b want 10", {udf[0], rdv[0]});
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; data_in = 16'(32'h3100 + i);
      tick();
    end
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    idle();
    for (int k = 0; k < N; k++) begin
      n_vec++;
      if ({emp[k], ae[k], ful[k], af[k], ack[k], ovf[k], udf[k], rdv[k]} !== 8'b1100_0000 ||
          cnt(k) !== 4'd0 || (!is_fwft(k) && dout[k] !== 16'h0000)) begin
        n_err++;
        $display("FAIL rst_burst[%0d]: got flags=%b cnt=%0d dout=%h want 11000000 cnt=0 dout=0000", k,
                 {emp[k], ae[k], ful[k], af[k], ack[k], ovf[k], udf[k], rdv[k]}, cnt(k), dout[k]);
      end
    end
  endtask

  task automatic test_fwft();
    do_reset();
    wr_en = 1'b1; data_in = 16'hABCD;
    tick();
    idle();
    for (int t = 0; t < 2; t++) begin
      n_vec++;
      if (dout[2] !== 16'hABCD || rdv[2] !== 1'b1 || emp[2] !== 1'b0) begin
        n_err++;
        $display("FAIL fwft_present[%0d]: got dout=%h rdv=%b empty=%b want abcd/1/0", t, dout[2], rdv[2], emp[2]);
      end
      tick();
    end
    rd_en = 1'b1;
    tick();
    idle();
    n_vec++;
    if ({rdv[2], emp[2]} !== 2'b01) begin
      n_err++;
      $display("FAIL fwft_pop: got rdv/empty=%b want 01", {rdv[2], emp[2]});
    end
  endtask

  task automatic test_random();
    int wb, rb, sz;
    logic [15:0] want;
    for (int c = 0; c < 800; c++) begin
      case (c / 200)
        0:       begin wb = 80; rb = 30; end
        1:       begin wb = 30; rb = 80; end
        2:       begin wb = 50; rb = 50; end
        default: begin wb = 75; rb = 75; end
      endcase
      rst     = ($urandom_range(0, 149) == 0);
      flush   = ($urandom_range(0, 59) == 0);
      wr_en   = ($urandom_range(0, 99) < wb);
      rd_en   = ($urandom_range(0, 99) < rb);
      data_in = 16'($urandom);
      tick();
      for (int k = 0; k < N; k++) begin
        sz = msize(k);
        n_vec++;
        if ({ful[k], emp[k], af[k], ae[k]} !== {sz == dep(k), sz == 0, sz >= afth(k), sz <= 2} ||
            cnt(k) !== 4'(sz)) begin
          n_err++;
          $display("FAIL rand_flags[%0d] c=%0d: got full/empty/af/ae=%b cnt=%0d want %b cnt=%0d", k, c,
                   {ful[k], emp[k], af[k], ae[k]}, cnt(k),
                   {sz == dep(k), sz == 0, sz >= afth(k), sz <= 2}, sz);
        end
        n_vec++;
        if ({ack[k], ovf[k], udf[k]} !== {e_ack[k], e_ovf[k], e_udf[k]}) begin
          n_err++;
          $display("FAIL rand_hs[%0d] c=%0d: got ack/ovf/udf=%b want %b", k, c,
                   {ack[k], ovf[k], udf[k]}, {e_ack[k], e_ovf[k], e_udf[k]});
        end
        n_vec++;
        if (is_fwft(k)) begin
          want = mfront(k);
          if (rdv[k] !== (sz != 0) || (sz != 0 && dout[k] !== want)) begin
            n_err++;
            $display("FAIL rand_fwft c=%0d: got rdv=%b dout=%h want rdv=%b dout=%h", c,
                     rdv[k], dout[k], sz != 0, want);
          end
        end else if ({rdv[k], dout[k]} !== {e_rdv[k], e_dout[k]}) begin
          n_err++;
          $display("FAIL rand_rd[%0d] c=%0d: got rdv=%b dout=%h want rdv=%b dout=%h", k, c,
                   rdv[k], dout[k], e_rdv[k], e_dout[k]);
        end
      end
    end
    idle();
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    data_in = 16'h0000;
    idle();
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simul();
    test_flush_rst();
    test_fwft();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, meaning data word width in bits (>=1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning number of storage entries (>=2; non-power-of-2 legal).
REQ-003 SHALL have parameter AF_THRESH, default FIFO_DEPTH-1, meaning almostfull asserted when count >= AF_THRESH.
REQ-004 SHALL have parameter AE_THRESH, default 1, meaning almostempty asserted when count <= AE_THRESH.
REQ-005 SHALL have parameter FWFT, default 0, meaning 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 SHALL reject at elaboration any configuration violating FIFO_DEPTH>=2 or 1 <= AE_THRESH < AF_THRESH <= FIFO_DEPTH-1.
REQ-007 SHALL have ports:
  clk  in  1  rising-edge clock, single domain
  rst  in  1  reset, synchronous, active-high
  flush  in  1  synchronous clear of contents, active-high
  wr_en  in  1  write request
  data_in  in  FIFO_WIDTH  write data
  rd_en  in  1  read request
  data_out  out  FIFO_WIDTH  read data
  rd_valid  out  1  data_out holds valid read data
  wr_ack  out  1  previous-cycle write accepted
  overflow  out  1  previous-cycle write rejected (full)
  underflow  out  1  previous-cycle read rejected (empty)
  full, empty, almostfull, almostempty  out  1 each  occupancy flags
  count  out  $clog2(FIFO_DEPTH+1)  current occupancy

Function
REQ-008 Write accepted iff wr_en && !full && !flush; read accepted iff rd_en && !empty && !flush; both evaluated on pre-edge state.
REQ-009 Simultaneous accepted read and write SHALL leave count unchanged; full blocks write even if a read is accepted same cycle; empty blocks read even if a write is accepted same cycle.
REQ-010 count SHALL increment on write-only, decrement on read-only, never exceed FIFO_DEPTH nor drop below 0.
REQ-011 wr_ptr/rd_ptr SHALL advance by one per accepted operation and wrap from FIFO_DEPTH-1 to 0 (modulo FIFO_DEPTH, not 2^n).
REQ-012 full = (count==FIFO_DEPTH), empty = (count==0), almostfull = (count>=AF_THRESH), almostempty = (count<=AE_THRESH); all decoded from registered count, no extra latency.
REQ-013 wr_ack SHALL be 1 for exactly the cycle after each accepted write, else 0.
REQ-014 overflow SHALL be 1 the cycle after wr_en while full (flush=0), else 0; underflow likewise for rd_en while empty.
REQ-015 FWFT=0: on accepted read, data_out SHALL load mem[rd_ptr] at that edge and rd_valid SHALL be 1 the following cycle only; data_out holds its value otherwise.
REQ-016 FWFT=1: data_out SHALL present head entry mem[rd_ptr] whenever !empty, rd_valid = !empty; rd_en acts as pop/acknowledge; data_out undefined-but-stable-irrelevant when empty (bench ignores).
REQ-017 flush SHALL at the edge zero count, wr_ptr, rd_ptr, wr_ack, overflow, underflow, rd_valid; memory and FWFT=0 data_out contents retained; flush overrides wr_en/rd_en.
REQ-018 Memory SHALL not be reset; writes to mem occur only on accepted writes.

Reset
REQ-019 rst=1 at a rising edge SHALL set count=0, pointers=0, data_out=0, rd_valid=0, wr_ack=0, overflow=0, underflow=0; hence empty=1, almostempty=1, full=0, almostfull=0.
REQ-020 rst SHALL take priority over flush, wr_en and rd_en, including mid-burst; no operation in a reset cycle is accepted.

Verification (FIFO_WIDTH=16, FIFO_DEPTH=8, AF_THRESH=6, AE_THRESH=2, FWFT=0 unless stated)
REQ-021 Reset then write 0x0001..0x0008 -> wr_ack each cycle after, almostempty drops at count=3, almostfull at count=6, full at count=8; ninth write -> overflow=1 next cycle, count stays 8.
REQ-022 From full, read 8 times -> data_out 0x0001..0x0008 in order, rd_valid 1 cycle after each read; ninth read -> underflow=1, empty=1.
REQ-023 FIFO_DEPTH=6: 20 interleaved write/read pairs with values 0x1000+i -> pointers wrap at 6, output order preserved, no flag glitches.
REQ-024 count=4, wr_en=rd_en=1 for 5 cycles -> count stays 4, wr_ack=1 each cycle; at full with both set -> only read accepted, overflow=1, count=7.
REQ-025 count=5, assert flush with wr_en=1 -> next cycle count=0, empty=1, wr_ack=0; rst during write burst -> all outputs at REQ-019 values.
REQ-026 FWFT=1: write 0xABCD into empty FIFO -> next cycle data_out=0xABCD, rd_valid=1 without rd_en; rd_en -> rd_valid=0, empty=1 next cycle.
